// File: rtl/fx2_rotmi_pipe_if.sv
// rtl/fx2_rotmi_pipe_if.sv - issue/writeback bundle for fx2_rotmi_pipe; arith exists only with FX2_ROTMAI_EN
interface fx2_rotmi_pipe_if #(
    parameter int REG_W = 7
);
    logic             valid_in;
    logic [0:127]     ra;
    logic [6:0]       imme7;
    logic [REG_W-1:0] rt_addr;
    logic             stall;
    logic             flush;
`ifdef FX2_ROTMAI_EN
    logic             arith;
`endif
    logic             valid_out;
    logic [0:127]     result;
    logic [REG_W-1:0] rt_addr_out;

    modport master (
`ifdef FX2_ROTMAI_EN
        output arith,
`endif
        output valid_in, ra, imme7, rt_addr, stall, flush,
        input  valid_out, result, rt_addr_out
    );

    modport slave (
`ifdef FX2_ROTMAI_EN
        input  arith,
`endif
        input  valid_in, ra, imme7, rt_addr, stall, flush,
        output valid_out, result, rt_addr_out
    );
endinterface

// File: rtl/fx2_rotmi_pipe.sv
// rtl/fx2_rotmi_pipe.sv - pipelined word-wise shift right by immediate (rotmi; rotmai with FX2_ROTMAI_EN)
module fx2_rotmi_pipe #(
    parameter int STAGES = 2,
    parameter int REG_W  = 7
) (
    input logic               clk,
    input logic               reset,
    fx2_rotmi_pipe_if.slave   bus
);
    logic [5:0]       cnt;
    logic [31:0]      word;
    logic [0:127]     shifted;
    logic             v_q   [STAGES];
    logic [0:127]     res_q [STAGES];
    logic [REG_W-1:0] rt_q  [STAGES];

    // Negated immediate modulo 64; counts of 32..63 shift the whole word out.
    assign cnt = 6'(7'd0 - bus.imme7);

    always_comb begin
        shifted = '0;
        word    = '0;
        for (int w = 0; w < 4; w++) begin
            word = bus.ra[32*w +: 32];
`ifdef FX2_ROTMAI_EN
            if (bus.arith)
                shifted[32*w +: 32] = $signed(word) >>> cnt;
            else
                shifted[32*w +: 32] = word >> cnt;
`else
            shifted[32*w +: 32] = word >> cnt;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < STAGES; s++) begin
                v_q[s]   <= 1'b0;
                res_q[s] <= '0;
                rt_q[s]  <= '0;
            end
        end else begin
            // Flush beats stall for the valid bits; data follows the stall rule only.
            if (bus.flush) begin
                for (int s = 0; s < STAGES; s++) v_q[s] <= 1'b0;
            end else if (!bus.stall) begin
                v_q[0] <= bus.valid_in;
                for (int s = 1; s < STAGES; s++) v_q[s] <= v_q[s-1];
            end
            if (!bus.stall) begin
                if (bus.valid_in) begin
                    res_q[0] <= shifted;
                    rt_q[0]  <= bus.rt_addr;
                end
                for (int s = 1; s < STAGES; s++) begin
                    if (v_q[s-1]) begin
                        res_q[s] <= res_q[s-1];
                        rt_q[s]  <= rt_q[s-1];
                    end
                end
            end
        end
    end

    assign bus.valid_out   = v_q[STAGES-1];
    assign bus.result      = res_q[STAGES-1];
    assign bus.rt_addr_out = rt_q[STAGES-1];
endmodule

// File: tb/tb_fx2_rotmi_pipe.sv
// tb/tb_fx2_rotmi_pipe.sv - directed and randomized bench for fx2_rotmi_pipe
module tb_fx2_rotmi_pipe;
    localparam int STAGES = 2;
    localparam int REG_W  = 7;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fx2_rotmi_pipe_if #(.REG_W(REG_W)) bus ();
    fx2_rotmi_pipe #(.STAGES(STAGES), .REG_W(REG_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [0:127]     res;
        logic [REG_W-1:0] rt;
        int               age;
    } op_t;
    op_t sb[$];

    function automatic logic [0:127] ref_shift(logic [0:127] ra, logic [6:0] imm, logic ar);
        int cnt;
        logic [0:127] r;
        logic [0:31]  t;
        logic         fill;
        cnt = (0 - int'($signed(imm))) & 63;
        r = '0;
        for (int w = 0; w < 4; w++) begin
            t = ra[32*w +: 32];
            fill = ar ? t[0] : 1'b0;
            for (int b = 0; b < 32; b++)
                r[32*w + b] = (b >= cnt) ? t[b - cnt] : fill;
        end
        return r;
    endfunction

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(logic v, logic [0:127] ra, logic [6:0] imm, logic [REG_W-1:0] rt,
                         logic st, logic fl, logic ar);
        bus.valid_in = v;
        bus.ra       = ra;
        bus.imme7    = imm;
        bus.rt_addr  = rt;
        bus.stall    = st;
        bus.flush    = fl;
`ifdef FX2_ROTMAI_EN
        bus.arith    = ar;
`endif
    endtask

    // One clock with scoreboard bookkeeping: ordering, stall hold, flush kill, latency.
    task automatic step(logic v, logic [0:127] ra, logic [6:0] imm, logic [REG_W-1:0] rt,
                        logic st, logic fl, logic ar);
        logic             pv;
        logic [0:127]     pr;
        logic [REG_W-1:0] prt;
        op_t              op;
        drive(v, ra, imm, rt, st, fl, ar);
        pv  = bus.valid_out;
        pr  = bus.result;
        prt = bus.rt_addr_out;
        @(posedge clk);
        #1;
        if (fl) begin
            sb.delete();
            chk("flush_valid", bus.valid_out, 0);
        end else if (st) begin
            chk("stall_hold_valid", bus.valid_out, pv);
            if (pv) begin
                chk("stall_hold_result", bus.result, pr);
                chk("stall_hold_rt", bus.rt_addr_out, prt);
            end
        end else begin
            foreach (sb[i]) sb[i].age++;
            if (bus.valid_out) begin
                if (sb.size() == 0) begin
                    chk("spurious_valid", bus.valid_out, 0);
                end else begin
                    op = sb.pop_front();
                    chk("result", bus.result, op.res);
                    chk("rt_addr_out", bus.rt_addr_out, op.rt);
                    chk("latency", op.age, STAGES - 1);
                end
            end else if (sb.size() > 0 && sb[0].age >= STAGES - 1) begin
                chk("dropped_op", bus.valid_out, 1);
            end
            if (v) sb.push_back('{ref_shift(ra, imm, ar), rt, 0});
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 7'h00, '0, 1'b0, 1'b0, 1'b0);
    endtask

    logic [0:127] r0, r1, r2;
    logic [6:0]   ri;
    logic         ra_bit;

    initial begin
        reset = 1'b1;
        drive(1'b0, '0, 7'h00, '0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", bus.valid_out, 0);
        chk("reset_result", bus.result, 0);
        chk("reset_rt", bus.rt_addr_out, 0);
        reset = 1'b0;

        // shift right by 4
        step(1'b1, {32'h8000_00F0, 96'h0}, 7'h7C, 7'd5, 1'b0, 1'b0, 1'b0);
        chk("t1_not_yet", bus.valid_out, 0);
        step(1'b0, '0, 7'h00, '0, 1'b0, 1'b0, 1'b0);
        chk("t1_valid", bus.valid_out, 1);
        chk("t1_word0", bus.result[0:31], 32'h0800_000F);

        // zero shift is identity
        step(1'b1, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FFFF_0000, 7'h00, 7'd9, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 7'h00, '0, 1'b0, 1'b0, 1'b0);
        chk("t2_identity", bus.result, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FFFF_0000);

        // count 60 clears every word
        step(1'b1, {4{32'hFFFF_FFFF}}, 7'h04, 7'd3, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 7'h00, '0, 1'b0, 1'b0, 1'b0);
        chk("t3_all_zero", bus.result, 0);
`ifdef FX2_ROTMAI_EN
        step(1'b1, {32'h8000_0000, 96'h0}, 7'h04, 7'd3, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 7'h00, '0, 1'b0, 1'b0, 1'b0);
        chk("t3_arith_sign", bus.result[0:31], 32'hFFFF_FFFF);
`endif

        // back-to-back with a 2-cycle stall on the first result
        r0 = {$urandom, $urandom, $urandom, $urandom};
        r1 = {$urandom, $urandom, $urandom, $urandom};
        r2 = {$urandom, $urandom, $urandom, $urandom};
        step(1'b1, r0, 7'h7F, 7'd10, 1'b0, 1'b0, 1'b0);
        step(1'b1, r1, 7'h70, 7'd11, 1'b0, 1'b0, 1'b0);
        chk("t4_op0_rt", bus.rt_addr_out, 7'd10);
        step(1'b1, r2, 7'h61, 7'd12, 1'b1, 1'b0, 1'b0);
        chk("t4_stall1_rt", bus.rt_addr_out, 7'd10);
        step(1'b1, r2, 7'h61, 7'd12, 1'b1, 1'b0, 1'b0);
        chk("t4_stall2_rt", bus.rt_addr_out, 7'd10);
        step(1'b1, r2, 7'h61, 7'd12, 1'b0, 1'b0, 1'b0);
        chk("t4_op1_rt", bus.rt_addr_out, 7'd11);
        step(1'b0, '0, 7'h00, '0, 1'b0, 1'b0, 1'b0);
        chk("t4_op2_rt", bus.rt_addr_out, 7'd12);
        step(1'b0, '0, 7'h00, '0, 1'b0, 1'b0, 1'b0);
        chk("t4_drained", bus.valid_out, 0);

        // flush a full pipe while issuing
        step(1'b1, r0, 7'h7E, 7'd20, 1'b0, 1'b0, 1'b0);
        step(1'b1, r1, 7'h7D, 7'd21, 1'b0, 1'b0, 1'b0);
        step(1'b1, r2, 7'h7C, 7'd22, 1'b0, 1'b1, 1'b0);
        idle(2);
        chk("t5_no_survivor", bus.valid_out, 0);
        step(1'b1, r2, 7'h78, 7'd23, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 7'h00, '0, 1'b0, 1'b0, 1'b0);
        chk("t5_after_flush_rt", bus.rt_addr_out, 7'd23);

        // flush together with stall still clears
        step(1'b1, r0, 7'h7E, 7'd24, 1'b0, 1'b0, 1'b0);
        step(1'b1, r1, 7'h7E, 7'd25, 1'b1, 1'b1, 1'b0);
        idle(2);

        // reset mid-stream under stall
        step(1'b1, r0, 7'h7E, 7'd30, 1'b0, 1'b0, 1'b0);
        step(1'b1, r1, 7'h7E, 7'd31, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        drive(1'b1, r2, 7'h7E, 7'd32, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("t6_valid", bus.valid_out, 0);
        chk("t6_result", bus.result, 0);
        chk("t6_rt", bus.rt_addr_out, 0);
        reset = 1'b0;
        sb.delete();
        idle(2);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            r0 = {$urandom, $urandom, $urandom, $urandom};
            ri = 7'($urandom);
            ra_bit = 1'b0;
`ifdef FX2_ROTMAI_EN
            ra_bit = 1'($urandom);
`endif
            step(($urandom_range(0, 9) < 7), r0, ri, REG_W'($urandom),
                 ($urandom_range(0, 9) < 2), ($urandom_range(0, 19) == 0), ra_bit);
        end
        idle(STAGES + 2);
        chk("drain_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
